// File: rtl/spi_mem_pkg.sv
// Shared command codes, FSM state type and byte-lane helpers for the SPI memory bridge.
package spi_mem_pkg;

    localparam logic [7:0] CMD_MEM_WR   = 8'h2A;
    localparam logic [7:0] CMD_MEM_RD   = 8'h2B;
    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        WR_DATA,
        RD_DATA,
        DISCARD
    } bridge_state_t;

    // Replace one little-endian byte lane of a 32-bit word.
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    // Pick one little-endian byte lane out of a 32-bit word.
    function automatic logic [7:0] lane_select(input logic [31:0] word,
                                               input logic [1:0]  lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select with one-cycle edge pulses.
module cs_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cs_n_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    // Next-state: shift raw cs_n through the synchroniser, remember last synced value.
    always_comb begin
        sync_d = {sync_q[0], cs_n_i};
        prev_d = sync_q[1];
    end

    // Registers reset to the idle (deselected) level so reset release never fakes an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;
    assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI byte-stream command decoder driving a 32-bit word memory port (host load/debug path).
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_byte_vld_i,
    input  logic [7:0]            spi_byte_data_i,
    output logic                  spi_byte_rdy_o,
    output logic [7:0]            spi_byte_data_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wr_data_o,
    output logic [3:0]            mem_wr_byte_en_o,
    input  logic [31:0]           mem_rd_data_i
);

    logic cs_rise, cs_fall;

    cs_sync u_cs_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .cs_n_i  (spi_cs_n_i),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    bridge_state_t         state_q, state_d;
    logic [1:0]            addr_cnt_q, addr_cnt_d;
    logic                  is_rd_q, is_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wr_buf_q, wr_buf_d;
    logic [3:0]            wr_be_q, wr_be_d;
    logic [31:0]           rd_word_q, rd_word_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wr_data_q, mem_wr_data_d;
    logic [3:0]            mem_wr_be_q, mem_wr_be_d;
    logic [1:0]            lane;

    assign lane = addr_q[1:0];

    // Decode one received byte per vld, then apply frame end (flush) after it.
    always_comb begin
        state_d       = state_q;
        addr_cnt_d    = addr_cnt_q;
        is_rd_d       = is_rd_q;
        addr_d        = addr_q;
        wr_buf_d      = wr_buf_q;
        wr_be_d       = wr_be_q;
        rd_word_d     = rd_word_q;
        mem_wr_en_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_be_d   = mem_wr_be_q;

        // Read-return tracker: a strobe travels RD_LATENCY stages before capture.
        rd_pipe_d[0] = mem_rd_en_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
        if (rd_pipe_q[RD_LATENCY-1]) begin
            rd_word_d = mem_rd_data_i;
        end

        if (cs_fall) begin
            state_d  = CMD;
            wr_buf_d = 32'h0;
            wr_be_d  = 4'h0;
        end

        if (spi_byte_vld_i) begin
            case (state_q)
                CMD: begin
                    addr_cnt_d = 2'd0;
                    addr_d     = '0;
                    if (spi_byte_data_i == CMD_MEM_WR) begin
                        state_d = ADDR;
                        is_rd_d = 1'b0;
                    end else if (spi_byte_data_i == CMD_MEM_RD) begin
                        state_d = ADDR;
                        is_rd_d = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                ADDR: begin
                    addr_d     = {addr_q[ADDR_WIDTH-9:0], spi_byte_data_i};
                    addr_cnt_d = addr_cnt_q + 2'd1;
                    if (addr_cnt_q == 2'd2) begin
                        if (is_rd_q) begin
                            state_d     = RD_DATA;
                            mem_rd_en_d = 1'b1;
                            mem_addr_d  = {addr_d[ADDR_WIDTH-1:2], 2'b00};
                        end else begin
                            state_d  = WR_DATA;
                            wr_buf_d = 32'h0;
                            wr_be_d  = 4'h0;
                        end
                    end
                end
                WR_DATA: begin
                    wr_buf_d       = lane_insert(wr_buf_q, lane, spi_byte_data_i);
                    wr_be_d[lane]  = 1'b1;
                    addr_d         = addr_q + ADDR_WIDTH'(1);
                    if (lane == 2'd3) begin
                        mem_wr_en_d   = 1'b1;
                        mem_addr_d    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                        mem_wr_data_d = wr_buf_d;
                        mem_wr_be_d   = wr_be_d;
                        wr_buf_d      = 32'h0;
                        wr_be_d       = 4'h0;
                    end
                end
                RD_DATA: begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    // Lane wraps 3 -> 0: prefetch the next word.
                    if (lane == 2'd3) begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {addr_d[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
                default: ;
            endcase
        end

        if (cs_rise) begin
            // Partial-word flush; skipped if this cycle's byte already completed the word.
            if (state_q == WR_DATA && !mem_wr_en_d && (wr_be_d != 4'h0)) begin
                mem_wr_en_d   = 1'b1;
                mem_addr_d    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_wr_data_d = wr_buf_d;
                mem_wr_be_d   = wr_be_d;
                wr_buf_d      = 32'h0;
                wr_be_d       = 4'h0;
            end
            state_d = CMD;
        end
    end

    // State, buffers and registered memory-port outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= CMD;
            addr_cnt_q    <= 2'd0;
            is_rd_q       <= 1'b0;
            addr_q        <= '0;
            wr_buf_q      <= 32'h0;
            wr_be_q       <= 4'h0;
            rd_word_q     <= 32'h0;
            rd_pipe_q     <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= 32'h0;
            mem_wr_be_q   <= 4'h0;
        end else begin
            state_q       <= state_d;
            addr_cnt_q    <= addr_cnt_d;
            is_rd_q       <= is_rd_d;
            addr_q        <= addr_d;
            wr_buf_q      <= wr_buf_d;
            wr_be_q       <= wr_be_d;
            rd_word_q     <= rd_word_d;
            rd_pipe_q     <= rd_pipe_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_be_q   <= mem_wr_be_d;
        end
    end

    assign spi_byte_rdy_o   = spi_byte_vld_i;
    assign spi_byte_data_o  = (state_q == RD_DATA) ? lane_select(rd_word_q, lane) : TX_IDLE_BYTE;
    assign mem_wr_en_o      = mem_wr_en_q;
    assign mem_rd_en_o      = mem_rd_en_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wr_data_o    = mem_wr_data_q;
    assign mem_wr_byte_en_o = mem_wr_be_q;

endmodule
